// File: rtl/vga_layer_mixer.sv
// N-layer priority pixel compositor with colour-key transparency, background colour and
// a CPU register bank whose configuration can be committed synchronously to vsync.
module vga_layer_mixer #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 12,
    parameter int ADDR_W     = 4,
    parameter int FCNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    we,
    input  logic                          rd,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [31:0]                   wdata,
    output logic [31:0]                   rdata,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]         layer_valid,
    input  logic                          blank_in,
    input  logic                          vsync_in,
    output logic [COLOR_W-1:0]            pixel_out,
    output logic                          pixel_blank,
    output logic                          irq
);

    localparam logic [31:0] EN_MASK   = 32'((64'd1 << NUM_LAYERS) - 64'd1);
    localparam logic [31:0] CTRL_MASK = EN_MASK | 32'h0003_0000;
    localparam logic [31:0] COL_MASK  = 32'((64'd1 << COLOR_W) - 64'd1);
    localparam logic [31:0] KEY_MASK  = COL_MASK | 32'h0100_0000;

    logic [31:0] ctrl_q, ctrl_d, bg_q, bg_d;
    logic [31:0] key_q [NUM_LAYERS];
    logic [31:0] key_d [NUM_LAYERS];

    logic [NUM_LAYERS-1:0] en_a_q, en_a_d, keyen_a_q, keyen_a_d;
    logic [COLOR_W-1:0]    bg_a_q, bg_a_d;
    logic [COLOR_W-1:0]    key_a_q [NUM_LAYERS];
    logic [COLOR_W-1:0]    key_a_d [NUM_LAYERS];

    logic                  vs_s1_q, vs_s2_q, vs_prev_q, vs_edge;
    logic                  commit_pend_q, commit_pend_d, irq_pend_q, irq_pend_d;
    logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [NUM_LAYERS*COLOR_W-1:0] col1_q;
    logic [NUM_LAYERS-1:0]         vis1_q, vis1_d;
    logic                          blank1_q, pblank_q;
    logic [COLOR_W-1:0]            pix_q, pix_d;

    logic [31:0] addr_w, byte_mask, status;
    logic        wr_cfg, commit, found;

    assign addr_w  = 32'(addr);
    assign vs_edge = vs_prev_q & ~vs_s2_q;
    assign commit  = vs_edge & commit_pend_q;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) byte_mask[8*k +: 8] = {8{we[k]}};
    end

    always_comb begin
        status = '0;
        status[0] = irq_pend_q;
        status[1] = commit_pend_q;
        status[16 +: FCNT_W] = fcnt_q;
    end

    // Shadow writes, commit bookkeeping, status and read-back
    always_comb begin
        ctrl_d = ctrl_q;
        bg_d   = bg_q;
        key_d  = key_q;
        wr_cfg = 1'b0;
        if (|we) begin
            if (addr_w == 32'd0) begin
                ctrl_d = ((ctrl_q & ~byte_mask) | (wdata & byte_mask)) & CTRL_MASK;
                wr_cfg = 1'b1;
            end
            if (addr_w == 32'd1) begin
                bg_d   = ((bg_q & ~byte_mask) | (wdata & byte_mask)) & COL_MASK;
                wr_cfg = 1'b1;
            end
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                if (addr_w == 32'(4 + i)) begin
                    key_d[i] = ((key_q[i] & ~byte_mask) | (wdata & byte_mask)) & KEY_MASK;
                    wr_cfg   = 1'b1;
                end
            end
        end

        commit_pend_d = commit_pend_q;
        if (commit) commit_pend_d = 1'b0;
        if (wr_cfg && ctrl_d[16]) commit_pend_d = 1'b1;

        irq_pend_d = irq_pend_q;
        if (we[0] && addr_w == 32'd2 && wdata[0]) irq_pend_d = 1'b0;
        if (vs_edge) irq_pend_d = 1'b1;

        fcnt_d = vs_edge ? fcnt_q + 1'b1 : fcnt_q;

        rdata_d = rdata_q;
        if (rd) begin
            rdata_d = '0;
            if (addr_w == 32'd0) rdata_d = ctrl_q;
            if (addr_w == 32'd1) rdata_d = bg_q;
            if (addr_w == 32'd2) rdata_d = status;
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                if (addr_w == 32'(4 + i)) rdata_d = key_q[i];
            end
        end
    end

    // With SYNC_UPD clear the active set simply trails the shadow by one cycle;
    // with it set, only a vsync commit (of the pre-write shadow) moves it.
    always_comb begin
        en_a_d    = en_a_q;
        bg_a_d    = bg_a_q;
        key_a_d   = key_a_q;
        keyen_a_d = keyen_a_q;
        if (!ctrl_q[16] || commit) begin
            en_a_d = ctrl_q[NUM_LAYERS-1:0];
            bg_a_d = bg_q[COLOR_W-1:0];
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                key_a_d[i]   = key_q[i][COLOR_W-1:0];
                keyen_a_d[i] = key_q[i][24];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            vis1_d[i] = layer_valid[i] & en_a_q[i] &
                        ~(keyen_a_q[i] & (layer_color[i*COLOR_W +: COLOR_W] == key_a_q[i]));
        end
    end

    always_comb begin
        pix_d = bg_a_q;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!found && vis1_q[i]) begin
                pix_d = col1_q[i*COLOR_W +: COLOR_W];
                found = 1'b1;
            end
        end
        if (blank1_q) pix_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q        <= '0;
            bg_q          <= '0;
            en_a_q        <= '0;
            bg_a_q        <= '0;
            keyen_a_q     <= '0;
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                key_q[i]   <= '0;
                key_a_q[i] <= '0;
            end
            vs_s1_q       <= 1'b1;
            vs_s2_q       <= 1'b1;
            vs_prev_q     <= 1'b1;
            commit_pend_q <= 1'b0;
            irq_pend_q    <= 1'b0;
            fcnt_q        <= '0;
            rdata_q       <= '0;
            col1_q        <= '0;
            vis1_q        <= '0;
            blank1_q      <= 1'b1;
            pix_q         <= '0;
            pblank_q      <= 1'b1;
        end else begin
            ctrl_q        <= ctrl_d;
            bg_q          <= bg_d;
            key_q         <= key_d;
            en_a_q        <= en_a_d;
            bg_a_q        <= bg_a_d;
            key_a_q       <= key_a_d;
            keyen_a_q     <= keyen_a_d;
            vs_s1_q       <= vsync_in;
            vs_s2_q       <= vs_s1_q;
            vs_prev_q     <= vs_s2_q;
            commit_pend_q <= commit_pend_d;
            irq_pend_q    <= irq_pend_d;
            fcnt_q        <= fcnt_d;
            rdata_q       <= rdata_d;
            col1_q        <= layer_color;
            vis1_q        <= vis1_d;
            blank1_q      <= blank_in;
            pix_q         <= pix_d;
            pblank_q      <= blank1_q;
        end
    end

    assign rdata       = rdata_q;
    assign pixel_out   = pix_q;
    assign pixel_blank = pblank_q;
    assign irq         = irq_pend_q & ctrl_q[17];

endmodule
